pid_scheduler: RTL and testbench

PID_SCHEDULER -- requirements
Module: pid_scheduler

---
 rtl/pid_scheduler.sv | 122 ++++++++++++
 tb/tb_pid_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_scheduler.sv
// pid_scheduler: round-robin scheduler sharing one PID core across four motors at a fixed control rate
// Ports:
//   CLK, reset           clock, asynchronous active-high reset
//   enable[3:0]          per-motor enable, sampled once per sweep at the tick
//   overrun_clear        clears the sticky overrun flag (a same-cycle overrun event wins)
//   pid_start, pid_motor request to the PID core and the motor it serves
//   pid_done, pid_duty   completion strobe and signed result from the PID core
//   duty0..duty3         registered signed duty per motor
//   cycle_done           one-cycle pulse when a sweep of all four motors ends
//   overrun              sticky: a tick arrived while a sweep was still running
//   timeout_err[3:0]     sticky per motor: the PID core did not answer in time
module pid_scheduler #(
    parameter int CLOCK_FREQ   = 16_000_000,
    parameter int CONTROL_FREQ = 1000,
    parameter int TIMEOUT      = 64
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [3:0]         enable,
    input  logic               overrun_clear,
    output logic               pid_start,
    output logic [1:0]         pid_motor,
    input  logic               pid_done,
    input  logic signed [23:0] pid_duty,
    output logic signed [23:0] duty0,
    output logic signed [23:0] duty1,
    output logic signed [23:0] duty2,
    output logic signed [23:0] duty3,
    output logic               cycle_done,
    output logic               overrun,
    output logic [3:0]         timeout_err
);
    localparam int PERIOD = CLOCK_FREQ / CONTROL_FREQ;
    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, STORE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      wcnt;
    logic [1:0]         idx;
    logic [3:0]         mask;
    logic signed [23:0] captured;
    logic signed [23:0] duty [4];
    logic               tick;
    logic               adv;

    assign tick  = cnt == CW'(PERIOD - 1);
    assign duty0 = duty[0];
    assign duty1 = duty[1];
    assign duty2 = duty[2];
    assign duty3 = duty[3];

    // Every state that finishes with the current motor funnels through one advance path
    assign adv = (state == SELECT && !mask[idx]) || state == STORE ||
                 (state == WAIT && !pid_done && wcnt == TW'(TIMEOUT - 1));

    // Free-running rate counter, never stalled by the sweep
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + CW'(1);
    end

    // Set has priority over clear so an overrun in the clearing cycle is not lost
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) overrun <= 1'b0;
        else       overrun <= (tick && state != IDLE) || (overrun && !overrun_clear);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            mask        <= '0;
            wcnt        <= '0;
            captured    <= '0;
            pid_start   <= 1'b0;
            pid_motor   <= '0;
            cycle_done  <= 1'b0;
            timeout_err <= '0;
            for (int i = 0; i < 4; i++) duty[i] <= '0;
        end else begin
            pid_start  <= 1'b0;
            cycle_done <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    mask  <= enable;
                    idx   <= '0;
                    state <= SELECT;
                end
                SELECT: if (mask[idx]) begin
                    pid_start <= 1'b1;
                    pid_motor <= idx;
                    state     <= ISSUE;
                end else begin
                    duty[idx] <= '0;
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: if (pid_done) begin
                    captured <= pid_duty;
                    state    <= STORE;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    duty[idx]        <= '0;
                    timeout_err[idx] <= 1'b1;
                end else begin
                    wcnt <= wcnt + TW'(1);
                end
                STORE: duty[idx] <= captured;
                default: state <= IDLE;
            endcase
            if (adv) begin
                idx        <= idx + 2'd1;
                state      <= idx == 2'd3 ? IDLE : SELECT;
                cycle_done <= idx == 2'd3;
            end
        end
    end
endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler: two schedulers (TIMEOUT 64 and 8) driven by one stimulus, checked every cycle against a sweep-schedule model
module tb_pid_scheduler;
    localparam int P = 100;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic [3:0] enable = 4'h0;
    logic overrun_clear = 1'b0;
    logic stray = 1'b0;

    logic               st [2];
    logic [1:0]         mo [2];
    logic               dn [2];
    logic signed [23:0] rd [2];
    logic signed [23:0] du [2][4];
    logic               cd [2];
    logic               ov [2];
    logic [3:0]         te [2];

    // PID core responder state
    logic               rdone [2];
    logic signed [23:0] rval [2];
    int                 rcnt [2];
    logic [1:0]         rmot [2];
    int                 lat [4];
    logic signed [23:0] val [4];

    // Model state
    int                 tov [2] = '{64, 8};
    int                 pst [2][4];
    int                 pdt [2][4];
    logic signed [23:0] pdv [2][4];
    bit                 ptf [2][4];
    int                 pend [2];
    bit                 act [2];
    logic signed [23:0] ed [2][4];
    logic [1:0]         em [2];
    bit                 eov [2];
    logic [3:0]         ete [2];
    int                 pulses [2];
    bit                 tk, busy, es;

    int n = 0, cur = 0, phase = 0;
    int passes = 0, total = 0;

    always #5 CLK = ~CLK;

    assign dn[0] = rdone[0] | stray;
    assign dn[1] = rdone[1] | stray;
    assign rd[0] = stray ? 24'sd555 : rval[0];
    assign rd[1] = stray ? 24'sd555 : rval[1];

    pid_scheduler #(.CLOCK_FREQ(1000), .CONTROL_FREQ(10), .TIMEOUT(64)) dut0 (
        .CLK(CLK), .reset(reset), .enable(enable), .overrun_clear(overrun_clear),
        .pid_start(st[0]), .pid_motor(mo[0]), .pid_done(dn[0]), .pid_duty(rd[0]),
        .duty0(du[0][0]), .duty1(du[0][1]), .duty2(du[0][2]), .duty3(du[0][3]),
        .cycle_done(cd[0]), .overrun(ov[0]), .timeout_err(te[0]));

    pid_scheduler #(.CLOCK_FREQ(1000), .CONTROL_FREQ(10), .TIMEOUT(8)) dut1 (
        .CLK(CLK), .reset(reset), .enable(enable), .overrun_clear(overrun_clear),
        .pid_start(st[1]), .pid_motor(mo[1]), .pid_done(dn[1]), .pid_duty(rd[1]),
        .duty0(du[1][0]), .duty1(du[1][1]), .duty2(du[1][2]), .duty3(du[1][3]),
        .cycle_done(cd[1]), .overrun(ov[1]), .timeout_err(te[1]));

    // PID core: answers lat[m] cycles after pid_start (0 = never); a new request cancels a pending one
    always @(posedge CLK) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            rdone[i] = 1'b0;
            if (reset) rcnt[i] = 0;
            else begin
                if (rcnt[i] > 0) begin
                    rcnt[i]--;
                    if (rcnt[i] == 0) begin
                        rdone[i] = 1'b1;
                        rval[i]  = val[rmot[i]];
                    end
                end
                if (st[i]) begin
                    rmot[i] = mo[i];
                    rcnt[i] = lat[mo[i]];
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input longint a, input longint e);
        total++;
        if (a == e) passes++;
        else $display("FAIL %s dut%0d n=%0d phase=%0d got %0d want %0d", nm, i, n, phase, a, e);
    endtask

    // Sweep schedule from a tick at t0: SELECT per motor, pid_start one cycle later,
    // duty visible after STORE / timeout / disabled write, cycle_done at the end
    task automatic plan(input int i, input int t0, input logic [3:0] m);
        int s = t0 + 1;
        for (int k = 0; k < 4; k++) begin
            pst[i][k] = -1;
            ptf[i][k] = 1'b0;
            pdv[i][k] = '0;
            if (!m[k]) begin
                pdt[i][k] = s + 1;
                s = s + 1;
            end else if (lat[k] != 0 && lat[k] <= tov[i]) begin
                pst[i][k] = s + 1;
                pdt[i][k] = s + 3 + lat[k];
                pdv[i][k] = val[k];
                s = s + 3 + lat[k];
            end else begin
                pst[i][k] = s + 1;
                pdt[i][k] = s + 2 + tov[i];
                ptf[i][k] = 1'b1;
                s = s + 2 + tov[i];
            end
        end
        pend[i] = s;
        act[i] = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (reset) begin
            n = 0;
            for (int i = 0; i < 2; i++) begin
                act[i] = 1'b0;
                em[i] = '0;
                eov[i] = 1'b0;
                ete[i] = '0;
                pulses[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    ed[i][k] = '0;
                    chk($sformatf("rst_duty%0d", k), i, du[i][k], 0);
                end
                chk("rst_start", i, st[i], 0);
                chk("rst_motor", i, mo[i], 0);
                chk("rst_cycle_done", i, cd[i], 0);
                chk("rst_overrun", i, ov[i], 0);
                chk("rst_timeout", i, te[i], 0);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                es = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (act[i] && pst[i][k] == n) begin
                        em[i] = 2'(k);
                        es = 1'b1;
                    end
                    if (act[i] && pdt[i][k] == n) begin
                        ed[i][k] = pdv[i][k];
                        if (ptf[i][k]) ete[i][k] = 1'b1;
                    end
                end
                chk("pid_start", i, st[i], es);
                chk("pid_motor", i, mo[i], em[i]);
                for (int k = 0; k < 4; k++) chk($sformatf("duty%0d", k), i, du[i][k], ed[i][k]);
                chk("cycle_done", i, cd[i], act[i] && n == pend[i]);
                chk("overrun", i, ov[i], eov[i]);
                chk("timeout_err", i, te[i], ete[i]);
                if (st[i]) pulses[i]++;
                tk = (n % P) == P - 1;
                busy = act[i] && n < pend[i];
                eov[i] = (tk && busy) || (eov[i] && !overrun_clear);
                if (tk && !busy) plan(i, n, enable);
            end
            if (phase == 0) begin
                if (n == 12) for (int i = 0; i < 2; i++) chk("lit_stray_ignored", i, du[i][0], 0);
                if (n == 120) for (int i = 0; i < 2; i++) chk("lit_cycle_done_21", i, cd[i], 1);
                if (n == 125) for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < 4; k++) chk($sformatf("lit_a_duty%0d", k), i, du[i][k], 100 + k);
                    chk("lit_a_pulses", i, pulses[i], 4);
                    pulses[i] = 0;
                end
                if (n == 215) for (int i = 0; i < 2; i++) begin
                    chk("lit_b_duty0", i, du[i][0], -500);
                    chk("lit_b_duty1", i, du[i][1], 0);
                    chk("lit_b_duty2", i, du[i][2], -500);
                    chk("lit_b_duty3", i, du[i][3], 0);
                    chk("lit_b_pulses", i, pulses[i], 2);
                end
                if (n == 390) for (int i = 0; i < 2; i++) begin
                    chk("lit_c_duty0", i, du[i][0], 10);
                    chk("lit_c_duty1", i, du[i][1], 20);
                    chk("lit_c_duty2", i, du[i][2], 0);
                    chk("lit_c_duty3", i, du[i][3], 40);
                    chk("lit_c_timeout", i, te[i], 4);
                end
                if (n == 510) begin
                    chk("lit_d_overrun", 0, ov[0], 1);
                    chk("lit_d_no_overrun", 1, ov[1], 0);
                end
                if (n == 530) chk("lit_d_overrun_cleared", 0, ov[0], 0);
                if (n == 580) begin
                    for (int k = 0; k < 4; k++) chk($sformatf("lit_e_duty%0d", k), 0, du[0][k], k + 1);
                    chk("lit_e_all_timeout", 1, te[1], 15);
                end
                if (n == 610) for (int k = 0; k < 4; k++) chk($sformatf("lit_e_zero%0d", k), 0, du[0][k], 0);
                if (n == 710) chk("lit_f_duty0", 0, du[0][0], 77);
            end else begin
                if (n == 100) chk("lit_g_no_start_yet", 0, st[0], 0);
                if (n == 101) begin
                    chk("lit_g_start", 0, st[0], 1);
                    chk("lit_g_motor", 0, mo[0], 0);
                end
            end
            n++;
        end
    end

    task automatic go(input int t);
        while (cur < t) begin
            @(posedge CLK);
            #2;
            cur++;
        end
    endtask

    task automatic cfg(input int l0, l1, l2, l3, input int v0, v1, v2, v3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        val[0] = 24'(v0); val[1] = 24'(v1); val[2] = 24'(v2); val[3] = 24'(v3);
    endtask

    initial begin
        cfg(2, 2, 2, 2, 100, 101, 102, 103);
        enable = 4'hF;
        #1 reset = 1'b1;
        repeat (3) @(posedge CLK);
        #2 reset = 1'b0;
        cur = 0;
        go(10); stray = 1'b1;
        go(11); stray = 1'b0;
        go(130); cfg(2, 2, 2, 2, -500, -500, -500, -500); enable = 4'b0101;
        go(230); cfg(2, 2, 0, 2, 10, 20, 30, 40); enable = 4'hF;
        go(395); cfg(40, 40, 40, 40, 1, 2, 3, 4);
        go(450); enable = 4'h0;
        go(499); overrun_clear = 1'b1;
        go(500); overrun_clear = 1'b0;
        go(520); overrun_clear = 1'b1;
        go(521); overrun_clear = 1'b0;
        go(620); cfg(2, 30, 2, 2, 77, 5, 6, 7); enable = 4'hF;
        go(715);
        #1 reset = 1'b1;
        phase = 1;
        repeat (3) @(posedge CLK);
        #2 reset = 1'b0;
        cur = 0;
        go(130);
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
